// File: rtl/l2_refill_engine.sv
// L2 refill engine: queues block-aligned miss addresses in a small FIFO and
// replays each one as a burst of beats after a fixed memory latency. Beat data
// comes from a simulated backing store (constant pattern XOR beat address).
module l2_refill_engine #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_SIZE  = 32,
  parameter int MEM_LATENCY = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_last,
  output logic                  busy
);

  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int BEATS          = BLOCK_SIZE / BYTES_PER_BEAT;
  localparam int OFFSET_WIDTH   = $clog2(BLOCK_SIZE);
  localparam int BEAT_W         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W          = PTR_W + 1;
  localparam int LAT_W          = 4;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~ADDR_WIDTH'((1 << OFFSET_WIDTH) - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(BEATS - 1);
  localparam logic [DATA_WIDTH-1:0] MEM_PATTERN = DATA_WIDTH'(32'hDEADBEEF);
  localparam logic [CNT_W-1:0]      FULL_COUNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [LAT_W-1:0]      LAT_LOAD    = LAT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] blk_addr;
  logic [LAT_W-1:0]      lat_cnt;
  logic [BEAT_W-1:0]     beat_idx;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  push;
  logic                  pop;

  // Full FIFO simply stalls the requester; there is no bypass path.
  assign req_ready = (count != FULL_COUNT);
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign beat_addr = blk_addr + ADDR_WIDTH'(beat_idx) * ADDR_WIDTH'(BYTES_PER_BEAT);

  // State register; reset abandons any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: pop, wait out the memory latency, then stream the block.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = BURST;
      BURST:   if (resp_ready && (beat_idx == LAST_BEAT)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are gated to zero outside BURST so reset and idle look identical.
  always_comb begin
    resp_valid = 1'b0;
    resp_last  = 1'b0;
    resp_addr  = '0;
    resp_data  = '0;
    busy       = (state != IDLE) || (count != '0);
    if (state == BURST) begin
      resp_valid = 1'b1;
      resp_last  = (beat_idx == LAST_BEAT);
      resp_addr  = beat_addr;
      resp_data  = MEM_PATTERN ^ DATA_WIDTH'(beat_addr);
    end
  end

  // FIFO storage holds block-aligned addresses only.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req_addr & ALIGN_MASK;
  end

  // Current-block register loads from the FIFO head on pop.
  always_ff @(posedge clk) begin
    if (pop) blk_addr <= fifo_mem[rd_ptr];
  end

  // FIFO pointers/occupancy plus latency and beat counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lat_cnt  <= '0;
      beat_idx <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        lat_cnt <= LAT_LOAD;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (state == WAIT) begin
        if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        else               beat_idx <= '0;
      end
      if ((state == BURST) && resp_ready) beat_idx <= beat_idx + 1'b1;
    end
  end

endmodule
